// File: rtl/pipe_mux_arb_pkg.sv
// rtl/pipe_mux_arb_pkg.sv - shared mode encoding for the pipelined selector/arbiter
package pipe_mux_arb_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

endpackage

// File: rtl/pipe_mux_arb_rr_pick.sv
// rtl/pipe_mux_arb_rr_pick.sv - combinational rotate-priority finder
// Searches req starting just after ptr, wrapping, and returns the first set index.
module rr_pick #(
  parameter  int N    = 8,
  localparam int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic            gnt_valid,
  output logic [SELW-1:0] gnt_idx
);

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (int'(ptr) + k) % N;
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = SELW'(idx);
      end
    end
  end

endmodule

// File: rtl/pipe_mux_arb.sv
// rtl/pipe_mux_arb.sv - N-input selector with fixed/round-robin grant and one output register
// out_ready reaches in_ready combinationally; out_data/out_valid come only from flops.
module pipe_mux_arb
  import pipe_mux_arb_pkg::*;
#(
  parameter  int N     = 8,
  parameter  int WIDTH = 32,
  localparam int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_src,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [SELW-1:0] rr_ptr;
  logic            rr_valid;
  logic [SELW-1:0] rr_idx;
  logic            can_accept;
  logic            fixed_valid;
  logic            grant_valid;
  logic [SELW-1:0] grant_idx;
  logic            xfer;

  rr_pick #(.N(N)) u_rr_pick (
    .req       (in_valid),
    .ptr       (rr_ptr),
    .gnt_valid (rr_valid),
    .gnt_idx   (rr_idx)
  );

  // Out-of-range select simply yields no grant.
  assign fixed_valid = (int'(sel) < N) && in_valid[sel];
  assign can_accept  = !out_valid || out_ready;
  assign grant_valid = (mode == MODE_RR) ? rr_valid : fixed_valid;
  assign grant_idx   = (mode == MODE_RR) ? rr_idx : sel;
  assign xfer        = !reset && grant_valid && can_accept;

  always_comb begin
    in_ready = '0;
    if (xfer) in_ready[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      rr_ptr    <= SELW'(N - 1);
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[int'(grant_idx)*WIDTH +: WIDTH];
      out_src   <= grant_idx;
      if (mode == MODE_RR) rr_ptr <= grant_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
